// File: rtl/nvdla_csb_arbiter.sv
// Round-robin arbiter that funnels N_REQ requester ports onto one CSB engine,
// one transaction at a time, with a per-transaction response timeout.
module nvdla_csb_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ-1:0]       req_write_i,
  input  logic [N_REQ-1:0][15:0] req_addr_i,
  input  logic [N_REQ-1:0][31:0] req_wdat_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [31:0]            rsp_rdat_o,
  output logic                   rsp_err_o,
  output logic                   csb_valid_o,
  input  logic                   csb_ready_i,
  output logic                   csb_write_o,
  output logic [15:0]            csb_addr_o,
  output logic [31:0]            csb_wdat_o,
  input  logic                   csb_rdat_valid_i,
  input  logic [31:0]            csb_rdat_i,
  input  logic                   csb_wr_complete_i,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW    = IDX_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, owner_q, pick_c;
  logic [CW-1:0]    cand;
  logic             found_c;
  logic             write_q, err_q;
  logic [15:0]      addr_q;
  logic [31:0]      wdat_q, rdat_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_c, accept_c, done_c, tmo_c, rd_done_c, wr_done_c;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_rdat_q;
  logic             rsp_err_q;

  // First valid port at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!found_c && req_valid_i[cand[IDX_W-1:0]]) begin
        found_c = 1'b1;
        pick_c  = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    grant_c     = 1'b0;
    accept_c    = 1'b0;
    done_c      = 1'b0;
    tmo_c       = 1'b0;
    rd_done_c   = !write_q && csb_rdat_valid_i;
    wr_done_c   = write_q && csb_wr_complete_i;
    case (state_q)
      S_IDLE: begin
        if (found_c && !clear_i) begin
          req_ready_o[pick_c] = 1'b1;
          grant_c             = 1'b1;
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (csb_ready_i) begin
          accept_c = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion in the final counted cycle beats the timeout
        if (rd_done_c || wr_done_c) begin
          done_c  = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_c   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= S_IDLE;
    else if (clear_i) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Latched command, timeout counter and registered response stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      cnt_q       <= '0;
      rdat_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdat_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (clear_i) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      cnt_q       <= '0;
      rdat_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdat_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (grant_c) begin
        owner_q  <= pick_c;
        write_q  <= req_write_i[pick_c];
        addr_q   <= req_addr_i[pick_c];
        wdat_q   <= req_wdat_i[pick_c];
        rr_ptr_q <= (pick_c == IDX_W'(N_REQ - 1)) ? '0 : pick_c + IDX_W'(1);
      end
      if (accept_c)              cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (done_c || tmo_c) begin
        rdat_q <= rd_done_c ? csb_rdat_i : '0;
        err_q  <= tmo_c;
      end
      rsp_valid_q <= (state_q == S_RESP) ? (N_REQ'(1) << owner_q) : '0;
      rsp_rdat_q  <= (state_q == S_RESP) ? rdat_q : '0;
      rsp_err_q   <= (state_q == S_RESP) && err_q;
    end
  end

  assign csb_valid_o = (state_q == S_ISSUE);
  assign csb_write_o = write_q;
  assign csb_addr_o  = addr_q;
  assign csb_wdat_o  = wdat_q;
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdat_o  = rsp_rdat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_nvdla_csb_arbiter.sv
// Scoreboard bench for nvdla_csb_arbiter: expected responses are queued at grant
// time and matched against each rsp_valid_o pulse.
module tb_nvdla_csb_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  logic               clk_i = 1'b0;
  logic               rst_ni, clear_i;
  logic [N-1:0]       req_valid_i, req_ready_o, req_write_i;
  logic [N-1:0][15:0] req_addr_i;
  logic [N-1:0][31:0] req_wdat_i;
  logic [N-1:0]       rsp_valid_o;
  logic [31:0]        rsp_rdat_o;
  logic               rsp_err_o;
  logic               csb_valid_o, csb_ready_i, csb_write_o;
  logic [15:0]        csb_addr_o;
  logic [31:0]        csb_wdat_o, csb_rdat_i;
  logic               csb_rdat_valid_i, csb_wr_complete_i, busy_o;

  nvdla_csb_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdat_i(req_wdat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdat_o(rsp_rdat_o), .rsp_err_o(rsp_err_o),
    .csb_valid_o(csb_valid_o), .csb_ready_i(csb_ready_i), .csb_write_o(csb_write_o),
    .csb_addr_o(csb_addr_o), .csb_wdat_o(csb_wdat_o),
    .csb_rdat_valid_i(csb_rdat_valid_i), .csb_rdat_i(csb_rdat_i),
    .csb_wr_complete_i(csb_wr_complete_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [N-1:0] oh;
  int unsigned cyc = 0;
  int unsigned last_rsp_cyc = 0;
  int unsigned rsp_total = 0;
  int unsigned g, prev;
  int          rsp_cnt[N];
  int          port;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Response side of the scoreboard plus per-cycle protocol invariants
  always @(negedge clk_i) begin
    check_eq("rdy_only_idle", 64'(busy_o && (req_ready_o != '0)), 64'(0));
    if (rsp_valid_o != '0) begin
      last_rsp_cyc = cyc;
      rsp_total++;
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
      end else begin
        e = sb.pop_front();
        oh = '0;
        oh[e.port] = 1'b1;
        check_eq("rsp_port", 64'(rsp_valid_o), 64'(oh));
        check_eq("rsp_rdat", 64'(rsp_rdat_o), 64'(e.rdat));
        check_eq("rsp_err", 64'(rsp_err_o), 64'(e.err));
        rsp_cnt[e.port]++;
      end
    end else begin
      check_eq("rsp_quiet", 64'({rsp_rdat_o, rsp_err_o}), 64'(0));
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_exp(input int p, input logic [31:0] d, input logic er);
    exp_t x;
    x.port = p;
    x.rdat = d;
    x.err  = er;
    sb.push_back(x);
  endtask

  task automatic wait_grant(output int p);
    int n = 0;
    p = -1;
    #1;
    while (req_ready_o == '0 && n < 40) begin
      tick();
      n++;
    end
    if (req_ready_o == '0) check_eq("grant_wait", 64'(req_ready_o != '0), 64'(1));
    else for (int i = 0; i < N; i++) if (req_ready_o[i]) p = i;
  endtask

  // Engine side: immediate accept, completion k cycles after accept
  task automatic serve(input bit drop, input bit wr, input int k, input logic [31:0] rd,
                       input logic [15:0] addr, input logic [31:0] wdat);
    tick();
    if (drop) req_valid_i = '0;
    check_eq("issue_cmd", 64'({csb_valid_o, csb_write_o, csb_addr_o, csb_wdat_o}),
             64'({1'b1, wr, addr, wdat}));
    csb_ready_i = 1'b1;
    tick();
    csb_ready_i = 1'b0;
    repeat (k - 1) tick();
    if (wr) csb_wr_complete_i = 1'b1;
    else begin
      csb_rdat_valid_i = 1'b1;
      csb_rdat_i       = rd;
    end
    tick();
    csb_wr_complete_i = 1'b0;
    csb_rdat_valid_i  = 1'b0;
    csb_rdat_i        = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0;
    req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_wdat_i = '0;
    csb_ready_i = 1'b0; csb_rdat_valid_i = 1'b0; csb_rdat_i = '0; csb_wr_complete_i = 1'b0;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy_o), 64'(0));
    check_eq("rst_csb", 64'({csb_valid_o, csb_write_o, csb_addr_o, csb_wdat_o}), 64'(0));
    check_eq("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_rdat_o}), 64'(0));
    rst_ni = 1'b1;
    tick();
    check_eq("idle_busy", 64'(busy_o), 64'(0));

    // Single read on port 0, data two cycles after accept
    req_valid_i = 4'b0001; req_addr_i[0] = 16'h0004;
    wait_grant(port);
    check_eq("b_grant", 64'(port), 64'(0));
    g = cyc;
    push_exp(0, 32'hDEADBEEF, 1'b0);
    serve(1'b1, 1'b0, 2, 32'hDEADBEEF, 16'h0004, 32'h0);
    tick();
    check_eq("b_latency", 64'(last_rsp_cyc - g), 64'(5));

    // Write on port 1 with engine stalled for 10 cycles
    req_valid_i = 4'b0010; req_write_i = 4'b0010;
    req_addr_i[1] = 16'h1000; req_wdat_i[1] = 32'h12345678;
    wait_grant(port);
    check_eq("d_grant", 64'(port), 64'(1));
    push_exp(1, 32'h0, 1'b0);
    tick();
    req_valid_i = '0;
    for (int i = 0; i < 10; i++) begin
      check_eq("d_stable", 64'({csb_valid_o, csb_write_o, csb_addr_o, csb_wdat_o}),
               64'({1'b1, 1'b1, 16'h1000, 32'h12345678}));
      csb_wr_complete_i = (i == 4);
      tick();
    end
    csb_wr_complete_i = 1'b0;
    check_eq("d_cycle11", 64'({csb_valid_o, csb_write_o, csb_addr_o, csb_wdat_o}),
             64'({1'b1, 1'b1, 16'h1000, 32'h12345678}));
    csb_ready_i = 1'b1;
    tick();
    csb_ready_i = 1'b0;
    check_eq("d_accepted", 64'({busy_o, csb_valid_o}), 64'(2'b10));
    csb_wr_complete_i = 1'b1;
    tick();
    csb_wr_complete_i = 1'b0;
    drain(10);

    // Read on port 2 that never completes: timeout
    req_valid_i = 4'b0100; req_write_i = '0; req_addr_i[2] = 16'h0200;
    prev = rsp_total;
    wait_grant(port);
    check_eq("e_grant", 64'(port), 64'(2));
    g = cyc;
    push_exp(2, 32'h0, 1'b1);
    tick(); req_valid_i = '0; csb_ready_i = 1'b1;
    tick(); csb_ready_i = 1'b0;
    repeat (16) tick();
    check_eq("e_not_early", 64'(rsp_total), 64'(prev));
    tick();
    check_eq("e_latency", 64'(last_rsp_cyc - g), 64'(19));

    // Read on port 3: stray write-completion ignored, data in last counted cycle wins
    req_valid_i = 4'b1000; req_addr_i[3] = 16'h0300;
    wait_grant(port);
    check_eq("f_grant", 64'(port), 64'(3));
    g = cyc;
    push_exp(3, 32'hCAFEF00D, 1'b0);
    tick(); req_valid_i = '0; csb_ready_i = 1'b1;
    tick(); csb_ready_i = 1'b0; csb_wr_complete_i = 1'b1;
    tick(); csb_wr_complete_i = 1'b0;
    repeat (14) tick();
    csb_rdat_valid_i = 1'b1; csb_rdat_i = 32'hCAFEF00D;
    tick();
    csb_rdat_valid_i = 1'b0; csb_rdat_i = '0;
    tick();
    check_eq("f_latency", 64'(last_rsp_cyc - g), 64'(19));

    // Write on port 0 with a stray read-data pulse before the real completion
    req_valid_i = 4'b0001; req_write_i = 4'b0001;
    req_addr_i[0] = 16'h0010; req_wdat_i[0] = 32'hA5A50001;
    wait_grant(port);
    check_eq("g_grant", 64'(port), 64'(0));
    g = cyc;
    push_exp(0, 32'h0, 1'b0);
    tick(); req_valid_i = '0; csb_ready_i = 1'b1;
    tick(); csb_ready_i = 1'b0; csb_rdat_valid_i = 1'b1; csb_rdat_i = 32'hFFFFFFFF;
    tick(); csb_rdat_valid_i = 1'b0; csb_rdat_i = '0;
    tick(); csb_wr_complete_i = 1'b1;
    tick(); csb_wr_complete_i = 1'b0;
    tick();
    check_eq("g_latency", 64'(last_rsp_cyc - g), 64'(6));

    // Clear while waiting on port 1: transaction abandoned, late data ignored
    req_valid_i = 4'b0010; req_write_i = '0;
    wait_grant(port);
    check_eq("h_grant", 64'(port), 64'(1));
    tick(); req_valid_i = '0; csb_ready_i = 1'b1;
    tick(); csb_ready_i = 1'b0;
    prev = rsp_total;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_eq("h_busy", 64'(busy_o), 64'(0));
    csb_rdat_valid_i = 1'b1; csb_rdat_i = 32'h5555AAAA;
    tick();
    csb_rdat_valid_i = 1'b0; csb_rdat_i = '0;
    repeat (4) tick();
    check_eq("h_no_rsp", 64'(rsp_total), 64'(prev));

    // All ports requesting writes continuously: rotation restarts at port 0
    for (int p = 0; p < N; p++) begin
      rsp_cnt[p]    = 0;
      req_addr_i[p] = 16'h0100 + 16'(p);
      req_wdat_i[p] = 32'hC0DE0000 + 32'(p);
    end
    req_write_i = '1;
    req_valid_i = '1;
    for (int t = 0; t < 5; t++) begin
      int xp;
      xp = t % N;
      wait_grant(port);
      check_eq("c_grant", 64'(port), 64'(xp));
      push_exp(xp, 32'h0, 1'b0);
      serve(t == 4, 1'b1, 1, 32'h0, 16'h0100 + 16'(xp), 32'hC0DE0000 + 32'(xp));
    end
    drain(10);
    for (int p = 0; p < N; p++) check_eq("c_rsp_count", 64'(rsp_cnt[p]), 64'((p == 0) ? 2 : 1));
    tick();
    check_eq("end_idle", 64'(busy_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
